cmp_seq_ctrl: RTL and testbench

CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

---
 rtl/cmp_seq_ctrl_pkg.sv | 13 +
 rtl/cmp_seq_ctrl_if.sv | 20 ++
 rtl/cmp_seq_ctrl_bit_eq.sv | 10 +
 rtl/cmp_seq_ctrl.sv | 113 +++++++++++
 tb/tb_cmp_seq_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: defaults and FSM encoding.
package cmp_seq_ctrl_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam bit DEF_EARLY_EXIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
// Handshake: start is sampled only while busy=0; once accepted, start is ignored
// until done has pulsed and busy has fallen back to 0.
interface cmp_seq_ctrl_if import cmp_seq_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (output start, a_in, b_in, input busy, done, eq, gt, lt);
  modport slave  (input start, a_in, b_in, output busy, done, eq, gt, lt);

endinterface

// File: rtl/cmp_seq_ctrl_bit_eq.sv
// Single-bit equality cell, time-shared over all operand bit positions.
module bit_eq (
  input  logic a,
  input  logic b,
  output logic equal
);

  assign equal = ~(a ^ b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Bit-serial unsigned comparator: scans latched operands MSB first, one bit per
// cycle, and reports eq/gt/lt with a one-cycle done pulse.
module cmp_seq_ctrl import cmp_seq_ctrl_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit EARLY_EXIT = DEF_EARLY_EXIT
) (
  input  logic           clk,
  input  logic           reset,
  cmp_seq_ctrl_if.slave  bus,
  output state_t         dbg_state
);

  localparam int             IW      = $clog2(WIDTH);
  localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mm_seen;
  logic             mm_gt;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic a_bit;
  logic b_bit;
  logic bit_equal;
  logic hit;
  logic finish;
  logic res_gt;
  logic res_lt;

  assign a_bit = a_q[idx];
  assign b_bit = b_q[idx];

  bit_eq u_bit_eq (
    .a     (a_bit),
    .b     (b_bit),
    .equal (bit_equal)
  );

  // The first mismatch decides the result; a remembered one wins over the current bit.
  assign hit    = mm_seen | ~bit_equal;
  assign finish = (idx == '0) | (EARLY_EXIT & ~bit_equal);
  assign res_gt = hit & (mm_seen ? mm_gt  : a_bit);
  assign res_lt = hit & (mm_seen ? ~mm_gt : b_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mm_seen <= 1'b0;
      mm_gt   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            idx     <= IDX_MSB;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            mm_seen <= 1'b0;
            mm_gt   <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            eq_q   <= ~hit;
            gt_q   <= res_gt;
            lt_q   <= res_lt;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
            if (!bit_equal && !mm_seen) begin
              mm_seen <= 1'b1;
              mm_gt   <= a_bit;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: two instances (early exit on/off) driven in lockstep and
// checked against a reference model derived from unsigned comparison rules.
module tb_cmp_seq_ctrl;
  import cmp_seq_ctrl_pkg::*;

  localparam int W = DEF_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  state_t       st0;
  state_t       st1;

  cmp_seq_ctrl_if #(.WIDTH(W)) if0 ();
  cmp_seq_ctrl_if #(.WIDTH(W)) if1 ();

  assign if0.start = start;
  assign if0.a_in  = a_in;
  assign if0.b_in  = b_in;
  assign if1.start = start;
  assign if1.a_in  = a_in;
  assign if1.b_in  = b_in;

  cmp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .dbg_state(st0));
  cmp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(st1));

  // scoreboard
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: {eq,gt,lt} and done latency
  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
    if (!ee || a == b) return W;
    for (int p = 0; p < W; p++)
      if (a[W-1-p] != b[W-1-p]) return p + 1;
    return W;
  endfunction

  // driver: one comparison on both instances, observed for a fixed window
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    int lat0, lat1, cnt0, cnt1;
    logic [2:0] res0, res1;
    lat0 = 0; lat1 = 0; cnt0 = 0; cnt1 = 0; res0 = '0; res1 = '0;
    exp_q.push_back(model_res(a, b));
    exp_q.push_back(model_res(a, b));
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_run", {31'd0, if0.busy}, 32'd1);
      if (if0.done) begin
        cnt0++;
        if (lat0 == 0) begin lat0 = k; res0 = {if0.eq, if0.gt, if0.lt}; end
      end
      if (if1.done) begin
        cnt1++;
        if (lat1 == 0) begin lat1 = k; res1 = {if1.eq, if1.gt, if1.lt}; end
      end
      if (disturb) begin
        if (k == 2 || k == 4) begin start = 1'b1; a_in = ~a; b_in = a ^ 8'h3c; end
        if (k == 3 || k == 5) start = 1'b0;
      end
    end
    check("lat_ee1",  lat0, model_lat(a, b, 1'b1));
    check("res_ee1",  {29'd0, res0}, {29'd0, exp_q.pop_front()});
    check("ndone_ee1", cnt0, 1);
    check("lat_ee0",  lat1, model_lat(a, b, 1'b0));
    check("res_ee0",  {29'd0, res1}, {29'd0, exp_q.pop_front()});
    check("ndone_ee0", cnt1, 1);
    check("idle_after", {31'd0, if0.busy | if1.busy}, 32'd0);
  endtask

  // start held high: back-to-back runs with one idle cycle between done and next run
  task automatic run_held(input logic [W-1:0] a, input logic [W-1:0] b);
    int got0[$], got1[$], want0[$], want1[$];
    int l0, l1;
    l0 = model_lat(a, b, 1'b1);
    l1 = model_lat(a, b, 1'b0);
    for (int t = l0; t <= 32; t += l0 + 2) want0.push_back(t);
    for (int t = l1; t <= 32; t += l1 + 2) want1.push_back(t);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (if0.done) begin
        got0.push_back(k);
        check("held_res0", {29'd0, if0.eq, if0.gt, if0.lt}, {29'd0, model_res(a, b)});
      end
      if (if1.done) begin
        got1.push_back(k);
        check("held_res1", {29'd0, if1.eq, if1.gt, if1.lt}, {29'd0, model_res(a, b)});
      end
    end
    start = 1'b0;
    check("held_n0", got0.size(), want0.size());
    check("held_n1", got1.size(), want1.size());
    for (int i = 0; i < got0.size() && i < want0.size(); i++) check("held_t0", got0[i], want0[i]);
    for (int i = 0; i < got1.size() && i < want1.size(); i++) check("held_t1", got1[i], want1[i]);
    repeat (12) @(posedge clk);
    #1 check("held_idle", {31'd0, if0.busy | if1.busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out0"}, {27'd0, if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, 32'd0);
    check({tag, "_out1"}, {27'd0, if1.busy, if1.done, if1.eq, if1.gt, if1.lt}, 32'd0);
    check({tag, "_st0"}, st0, IDLE);
    check({tag, "_st1"}, st1, IDLE);
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    run_cmp(8'hA5, 8'hA5, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0);
    run_cmp(8'h12, 8'h13, 1'b0);
    run_cmp(8'h00, 8'h00, 1'b1);

    // abort a run on FF vs FE with an asynchronous reset in its third cycle
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if0.done || if1.done) done_seen++;
    end
    check("abort_nodone", done_seen, 0);
    run_cmp(8'h01, 8'h01, 1'b0);

    run_held(8'h80, 8'h00);
    run_held(8'h33, 8'h31);

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom_range(0, (1 << W) - 1));
      endcase
      run_cmp(ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
